cardinal_vc_buffer: RTL

Two-virtual-channel packet buffer that sits directly upstream of each router input port on the Cardinal bidirectional ring. It accepts 64-bit packets from the node's NIC output channel or a neighbouring router, stores them in per-VC FIFOs selected by packet bit 0, and forwards the head of the VC whose number matches the current ring polarity. It replaces the single-entry channel buffer on the NIC-to-ring path so that `cmp` can sustain back-to-back traffic without stalling the processors.

---
 rtl/cardinal_pkg.sv | 19 +
 rtl/cardinal_sync_fifo.sv | 50 +++++
 rtl/cardinal_vc_buffer.sv | 81 ++++++++
 3 files changed

// File: rtl/cardinal_pkg.sv
`default_nettype none
// ==== cardinal_pkg (rev 1.0): packet layout and sizing shared by the Cardinal NIC, ring and VC buffer ====
package cardinal_pkg;

  localparam int PKT_W         = 64;
  localparam int VC_BIT        = 0;
  localparam int DIR_BIT       = 1;
  localparam int HOP_MSB       = 8;
  localparam int HOP_LSB       = 15;
  localparam int DATA_MSB      = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

endpackage
`default_nettype wire

// File: rtl/cardinal_sync_fifo.sv
`default_nettype none
// ==== cardinal_sync_fifo (rev 1.0): single-clock FIFO, WIDTH x DEPTH, power-of-two depth ====
module cardinal_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [0:WIDTH-1]       wdata,
  output logic [0:WIDTH-1]       rdata,
  output logic [0:$clog2(DEPTH)] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/cardinal_vc_buffer.sv
`default_nettype none
// ==== cardinal_vc_buffer (rev 1.0): two-VC input buffer, head of VC[polarity] forwarded each cycle ====
module cardinal_vc_buffer
  import cardinal_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   si,
  input  logic [0:PKT_W-1]       di,
  output logic [0:1]             ri,
  output logic                   so,
  output logic [0:PKT_W-1]       dout,
  input  logic                   ro,
  output logic                   polarity,
  output logic [0:$clog2(DEPTH)] cnt0,
  output logic [0:$clog2(DEPTH)] cnt1
);

  vc_e              pol;
  logic [0:PKT_W-1] head0;
  logic [0:PKT_W-1] head1;
  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic             push0;
  logic             push1;
  logic             pop0;
  logic             pop1;

  always_ff @(posedge clk) begin
    if (!reset) pol <= VC0;
    else        pol <= (pol == VC0) ? VC1 : VC0;
  end

  // Readiness comes from registered counts only, so a same-cycle pop never admits a push into a full VC.
  assign push0 = si && (di[VC_BIT] == VC0) && !full0;
  assign push1 = si && (di[VC_BIT] == VC1) && !full1;

  assign so   = (pol == VC0) ? !empty0 : !empty1;
  assign pop0 = so && ro && (pol == VC0);
  assign pop1 = so && ro && (pol == VC1);

  assign dout     = !so ? '0 : ((pol == VC0) ? head0 : head1);
  assign ri       = {!full0, !full1};
  assign polarity = pol;

  cardinal_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo_vc0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .wdata (di),
    .rdata (head0),
    .count (cnt0),
    .full  (full0),
    .empty (empty0)
  );

  cardinal_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W)
  ) u_fifo_vc1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .wdata (di),
    .rdata (head1),
    .count (cnt1),
    .full  (full1),
    .empty (empty1)
  );

endmodule
`default_nettype wire
